// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between the burst reader, its request source, the peek FIFO and the sink.
// Latency: n/a (wires only). Backpressure: m_ready from the sink, fifo_empty from the FIFO.
// Modport master is the reader itself; slave is the surrounding environment.
interface fifo_burst_reader_if #(
    parameter int DATAW = 64,
    parameter int LENW  = 8
);
    logic             req_valid;
    logic [LENW-1:0]  req_len;
    logic             req_ready;
    logic [DATAW-1:0] fifo_odata;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             m_valid;
    logic [DATAW-1:0] m_data;
    logic             m_last;
    logic             m_ready;
    logic             done;
    logic             err;
    logic [LENW-1:0]  beats_sent;

    modport master (
        input  req_valid, req_len, fifo_odata, fifo_empty, m_ready,
        output req_ready, fifo_pop, m_valid, m_data, m_last, done, err, beats_sent
    );

    modport slave (
        output req_valid, req_len, fifo_odata, fifo_empty, m_ready,
        input  req_ready, fifo_pop, m_valid, m_data, m_last, done, err, beats_sent
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops a requested number of words from a peek FIFO onto a registered valid/ready stream with last flag.
// Latency: word on m_data one cycle after its pop; done one cycle after last-beat handshake.
// Backpressure: output register holds while m_valid&!m_ready; optional WATCHDOG_EN aborts stalled bursts.
module fifo_burst_reader #(
    parameter int DATAW   = 64,
    parameter int LENW    = 8,
    parameter int TIMEOUT = 1024,
    parameter int TOW     = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_burst_reader_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_BURST, S_FLUSH, S_DONE} state_t;

    state_t           r_state;
    logic [LENW-1:0]  r_len;
    logic [LENW-1:0]  r_pops;
    logic [LENW-1:0]  r_beats;
    logic [DATAW-1:0] r_m_data;
    logic             r_m_valid;
    logic             r_m_last;
    logic             r_done;
    logic             r_err;
    logic             r_req_ready;

    logic             w_pop;
    logic             w_hs;
    logic             w_final_pop;
    logic             w_abort;

    if (TOW < $clog2(TIMEOUT + 1)) begin : g_tow_check
        $error("TOW too narrow for TIMEOUT");
    end

    assign w_hs        = r_m_valid & bus.m_ready;
    // Gated by rst so a reset landing mid-burst never advances the FIFO head.
    assign w_pop       = !rst && (r_state == S_BURST) && !bus.fifo_empty &&
                         (r_pops < r_len) && (!r_m_valid || bus.m_ready);
    assign w_final_pop = (r_pops == r_len - 1'b1);

`ifdef WATCHDOG_EN
    logic [TOW-1:0] r_wd;

    assign w_abort = ((r_state == S_BURST) || (r_state == S_FLUSH)) &&
                     !w_pop && !w_hs && (r_wd == TOW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || w_pop || w_hs || !((r_state == S_BURST) || (r_state == S_FLUSH)))
            r_wd <= '0;
        else
            r_wd <= r_wd + 1'b1;
    end
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_pops      <= '0;
            r_beats     <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_len       <= bus.req_len;
                        r_pops      <= '0;
                        r_beats     <= '0;
                        if (bus.req_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    if (w_hs)
                        r_beats <= r_beats + 1'b1;
                    if (w_abort) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else if (w_pop) begin
                        r_m_data  <= bus.fifo_odata;
                        r_m_valid <= 1'b1;
                        r_m_last  <= w_final_pop;
                        r_pops    <= r_pops + 1'b1;
                        if (w_final_pop)
                            r_state <= S_FLUSH;
                    end else if (w_hs) begin
                        r_m_valid <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (w_abort) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else if (w_hs) begin
                        r_beats   <= r_beats + 1'b1;
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.fifo_pop   = w_pop;
    assign bus.m_valid    = r_m_valid;
    assign bus.m_data     = r_m_data;
    assign bus.m_last     = r_m_last;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.beats_sent = r_beats;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural peek FIFO and output monitor.
module tb_fifo_burst_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DATAW(64), .LENW(8)) bus();

    fifo_burst_reader #(.DATAW(64), .LENW(8), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int failures = 0;

    // FIFO model: write side owned by the initial block, read side by the monitor.
    logic [63:0] mem [0:15];
    int f_wr = 0;
    int f_rd = 0;
    assign bus.fifo_empty = (f_rd == f_wr);
    assign bus.fifo_odata = mem[f_rd % 16];

    logic [63:0] rx_data [0:63];
    logic        rx_last [0:63];
    int rx_n = 0, pop_cnt = 0, bad_pop = 0, bad_stable = 0, valid_cnt = 0, done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(posedge clk) begin
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            rx_data[rx_n % 64] <= bus.m_data;
            rx_last[rx_n % 64] <= bus.m_last;
            rx_n <= rx_n + 1;
        end
        if (bus.fifo_pop === 1'b1) begin
            f_rd    <= f_rd + 1;
            pop_cnt <= pop_cnt + 1;
            if (f_rd == f_wr) bad_pop <= bad_pop + 1;
            if (bus.m_valid === 1'b1 && bus.m_ready !== 1'b1) bad_pop <= bad_pop + 1;
        end
        if (bus.m_valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
        if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last))
            bad_stable <= bad_stable + 1;
        prev_stall <= (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
        prev_data  <= bus.m_data;
        prev_last  <= bus.m_last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] d);
        mem[f_wr % 16] = d;
        f_wr = f_wr + 1;
    endtask

    task automatic request(input logic [7:0] len);
        bus.req_valid = 1'b1;
        bus.req_len   = len;
        tick();
        bus.req_valid = 1'b0;
        bus.req_len   = 8'hEE;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, "_pop"},       64'(bus.fifo_pop),  64'd0);
        chk({tag, "_m_valid"},   64'(bus.m_valid),   64'd0);
        chk({tag, "_m_data"},    bus.m_data,         64'd0);
        chk({tag, "_m_last"},    64'(bus.m_last),    64'd0);
        chk({tag, "_done"},      64'(bus.done),      64'd0);
        chk({tag, "_err"},       64'(bus.err),       64'd0);
        chk({tag, "_beats"},     64'(bus.beats_sent), 64'd0);
    endtask

    initial begin
        int base_rx, base_pop, base_valid, base_done, k;
        logic seen;

        bus.req_valid = 1'b0;
        bus.req_len   = '0;
        bus.m_ready   = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();

        // 1: len=4, always ready, no bubbles
        for (int i = 0; i < 4; i++) push(64'hA000_0000_0000_0000 + 64'(i));
        request(8'd4);
        chk("t1_pop0", 64'(bus.fifo_pop), 64'd1);
        chk("t1_mv0",  64'(bus.m_valid),  64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t1_mv%0d", i),   64'(bus.m_valid), 64'd1);
            chk($sformatf("t1_data%0d", i), bus.m_data, 64'hA000_0000_0000_0000 + 64'(i));
            chk($sformatf("t1_last%0d", i), 64'(bus.m_last), (i == 3) ? 64'd1 : 64'd0);
            chk($sformatf("t1_pop%0d", i + 1), 64'(bus.fifo_pop), (i < 3) ? 64'd1 : 64'd0);
        end
        tick();
        chk("t1_done",  64'(bus.done),       64'd1);
        chk("t1_err",   64'(bus.err),        64'd0);
        chk("t1_beats", 64'(bus.beats_sent), 64'd4);
        chk("t1_mv_end", 64'(bus.m_valid),   64'd0);
        tick();
        chk("t1_done_pulse", 64'(bus.done),  64'd0);
        chk("t1_idle",  64'(bus.req_ready),  64'd1);
        chk("t1_hold_beats", 64'(bus.beats_sent), 64'd4);

        // 2: len=4, alternating m_ready
        base_rx = rx_n; base_pop = pop_cnt;
        for (int i = 0; i < 4; i++) push(64'hC000_0000_0000_0000 + 64'(i));
        request(8'd4);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.done === 1'b1) seen = 1'b1;
            else bus.m_ready = ~bus.m_ready;
        end
        bus.m_ready = 1'b1;
        chk("t2_done_seen", 64'(seen), 64'd1);
        chk("t2_rx_count", 64'(rx_n - base_rx), 64'd4);
        chk("t2_pops", 64'(pop_cnt - base_pop), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_data%0d", i), rx_data[(base_rx + i) % 64], 64'hC000_0000_0000_0000 + 64'(i));
            chk($sformatf("t2_last%0d", i), 64'(rx_last[(base_rx + i) % 64]), (i == 3) ? 64'd1 : 64'd0);
        end
        chk("t2_stable", 64'(bad_stable), 64'd0);
        chk("t2_pop_rules", 64'(bad_pop), 64'd0);
        chk("t2_beats", 64'(bus.beats_sent), 64'd4);
        tick();

        // 3: len=3, FIFO runs dry after one word
        base_rx = rx_n; base_pop = pop_cnt;
        push(64'hB0);
        request(8'd3);
        repeat (10) tick();
        chk("t3_gap_mv", 64'(bus.m_valid), 64'd0);
        chk("t3_gap_pop", 64'(bus.fifo_pop), 64'd0);
        chk("t3_gap_beats", 64'(bus.beats_sent), 64'd1);
        chk("t3_gap_pops", 64'(pop_cnt - base_pop), 64'd1);
        push(64'hB1);
        push(64'hB2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("t3_done_seen", 64'(seen), 64'd1);
        chk("t3_rx_count", 64'(rx_n - base_rx), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_data%0d", i), rx_data[(base_rx + i) % 64], 64'hB0 + 64'(i));
            chk($sformatf("t3_last%0d", i), 64'(rx_last[(base_rx + i) % 64]), (i == 2) ? 64'd1 : 64'd0);
        end
        chk("t3_pop_rules", 64'(bad_pop), 64'd0);
        tick();

        // 4: zero-length request
        base_pop = pop_cnt; base_valid = valid_cnt;
        request(8'd0);
        chk("t4_done", 64'(bus.done), 64'd1);
        chk("t4_beats", 64'(bus.beats_sent), 64'd0);
        chk("t4_busy", 64'(bus.req_ready), 64'd0);
        tick();
        chk("t4_done_pulse", 64'(bus.done), 64'd0);
        chk("t4_no_pop", 64'(pop_cnt - base_pop), 64'd0);
        chk("t4_no_valid", 64'(valid_cnt - base_valid), 64'd0);
        chk("t4_idle", 64'(bus.req_ready), 64'd1);

        // 6: FIFO holds one word of a len=4 burst
        base_done = done_cnt;
        push(64'hE0);
        request(8'd4);
`ifdef WATCHDOG_EN
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            tick();
            if (bus.done === 1'b1) k = i;
        end
        chk("t6_wd_cycle", 64'(k), 64'd18);
        chk("t6_wd_err", 64'(bus.err), 64'd1);
        chk("t6_wd_beats", 64'(bus.beats_sent), 64'd1);
        chk("t6_wd_mv", 64'(bus.m_valid), 64'd0);
        tick();
        chk("t6_wd_err_pulse", 64'(bus.err), 64'd0);
        chk("t6_wd_idle", 64'(bus.req_ready), 64'd1);
`else
        k = 0;
        repeat (30) tick();
        chk("t6_no_done", 64'(done_cnt - base_done), 64'd0);
        chk("t6_beats", 64'(bus.beats_sent), 64'd1);
        chk("t6_mv", 64'(bus.m_valid), 64'd0);
        chk("t6_busy", 64'(bus.req_ready), 64'd0);
        chk("t6_err", 64'(bus.err), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_recover", 64'(bus.req_ready), 64'd1);
`endif
        tick();

        // 5: reset mid-burst, then a fresh len=1 burst
        base_pop = pop_cnt; base_done = done_cnt;
        for (int i = 0; i < 8; i++) push(64'hD000_0000_0000_0000 + 64'(i));
        request(8'd8);
        tick();
        tick();
        tick();
        chk("t5_beats2", 64'(bus.beats_sent), 64'd2);
        chk("t5_pops3", 64'(pop_cnt - base_pop), 64'd3);
        rst = 1'b1;
        tick();
        chk_reset("t5_rst");
        rst = 1'b0;
        tick();
        chk("t5_no_done", 64'(done_cnt - base_done), 64'd0);
        chk("t5_pops_after_rst", 64'(pop_cnt - base_pop), 64'd3);
        request(8'd1);
        chk("t5_pop", 64'(bus.fifo_pop), 64'd1);
        tick();
        chk("t5_mv", 64'(bus.m_valid), 64'd1);
        chk("t5_data", bus.m_data, 64'hD000_0000_0000_0003);
        chk("t5_last", 64'(bus.m_last), 64'd1);
        tick();
        chk("t5_done", 64'(bus.done), 64'd1);
        chk("t5_beats1", 64'(bus.beats_sent), 64'd1);
        chk("t5_err", 64'(bus.err), 64'd0);
        tick();
        chk("final_pop_rules", 64'(bad_pop), 64'd0);
        chk("final_stable", 64'(bad_stable), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
